// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: word width, opcodes, fetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int WORD_W = 16;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_MOVI = 5'b00011;
  localparam logic [4:0] OP_LODR = 5'b00100;
  localparam logic [4:0] OP_STO  = 5'b00101;
  localparam logic [4:0] OP_JMP  = 5'b00110;
  localparam logic [4:0] OP_JEQ  = 5'b00111;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC candidates: sequential wrap, range-checked redirect target, optional JMP prediction.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides which candidate to load.
// Optional feature: IF_JMP_PREDICT_EN turns a fetched JMP into an immediate PC-relative jump.
module pc_next
  import cpu_pkg::*;
#(
  parameter int IMEM_DEPTH = 30
) (
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] ins,
  input  logic [WORD_W-1:0] target,
  output logic [WORD_W-1:0] redir_pc,
  output logic [WORD_W-1:0] adv_pc
);

  localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(IMEM_DEPTH);
  localparam logic [WORD_W-1:0] LAST_PC = WORD_W'(IMEM_DEPTH - 1);

  logic [WORD_W-1:0] seq_pc;

  // Sequential successor wraps to 0 after the last IMEM word; out-of-range targets collapse to 0.
  always_comb begin
    seq_pc   = (pc == LAST_PC) ? '0 : pc + 16'd1;
    redir_pc = (target >= DEPTH_W) ? '0 : target;
  end

`ifdef IF_JMP_PREDICT_EN
  logic [WORD_W-1:0] jmp_sum;

  // A JMP seen at fetch is taken right away: PC plus sign-extended 8-bit offset, same range rule.
  always_comb begin
    jmp_sum = pc + {{8{ins[7]}}, ins[7:0]};
    if (ins[15:11] == OP_JMP) begin
      adv_pc = (jmp_sum >= DEPTH_W) ? '0 : jmp_sum;
    end else begin
      adv_pc = seq_pc;
    end
  end
`else
  // Without prediction every instruction, JMP included, advances sequentially.
  logic unused_ins;
  assign unused_ins = ^ins;
  assign adv_pc     = seq_pc;
`endif

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch: owns the PC, drives Addr from it and registers Ins into IF/ID (IR/NPC/Valid).
// Latency: Addr follows PC in zero cycles; IR updates one edge after its address; redirect costs one NOP bubble.
// Backpressure: Stall holds PC and IF/ID; Redirect overrides Stall and flushes IF/ID.
// Optional feature: IF_JMP_PREDICT_EN (handled in pc_next) makes fetched JMPs redirect the PC at once.
module ins_fetch
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = 16'h0000,
  parameter int                IMEM_DEPTH = 30,
  parameter logic [WORD_W-1:0] NOP_WORD   = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [WORD_W-1:0] Addr,
  input  logic [WORD_W-1:0] Ins,
  input  logic              Stall,
  input  logic              Redirect,
  input  logic [WORD_W-1:0] Target,
  output logic [WORD_W-1:0] IR,
  output logic [WORD_W-1:0] NPC,
  output logic              Valid,
  output logic              Fetching
);

  fetch_state_t      state;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] redir_pc;
  logic [WORD_W-1:0] adv_pc;

  assign Addr = pc;

  pc_next #(
    .IMEM_DEPTH(IMEM_DEPTH)
  ) u_pc_next (
    .pc      (pc),
    .ins     (Ins),
    .target  (Target),
    .redir_pc(redir_pc),
    .adv_pc  (adv_pc)
  );

  // Fetch FSM: boot bubble, then Redirect > Stall > advance in both RUN and HOLD.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      IR       <= NOP_WORD;
      NPC      <= '0;
      Valid    <= 1'b0;
      Fetching <= 1'b0;
      state    <= S_BOOT;
    end else begin
      case (state)
        S_BOOT: begin
          state    <= S_RUN;
          Fetching <= 1'b1;
        end
        S_RUN, S_HOLD: begin
          if (Redirect) begin
            pc       <= redir_pc;
            IR       <= NOP_WORD;
            NPC      <= '0;
            Valid    <= 1'b0;
            state    <= S_RUN;
            Fetching <= 1'b1;
          end else if (Stall) begin
            state    <= S_HOLD;
            Fetching <= 1'b0;
          end else begin
            IR       <= Ins;
            NPC      <= pc + 16'd1;
            Valid    <= 1'b1;
            pc       <= adv_pc;
            state    <= S_RUN;
            Fetching <= 1'b1;
          end
        end
        default: begin
          state    <= S_BOOT;
          Fetching <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ins_fetch.sv
// Scoreboard bench for ins_fetch: the stimulus side predicts each cycle's IF/ID view, a monitor compares.
// Latency: expectations are checked 1 time unit after every rising edge.
// Backpressure: exercised through directed and random Stall/Redirect patterns.
module tb_ins_fetch;

  localparam int DEPTH = 30;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] ir;
    logic [15:0] npc;
    logic        valid;
    logic        fetching;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [15:0] ins;
  logic        stall;
  logic        redirect;
  logic [15:0] target;
  logic [15:0] ir;
  logic [15:0] npc;
  logic        valid;
  logic        fetching;

  logic [15:0] rom [DEPTH];
  obs_t        exp_q [$];
  int          checks = 0;
  int          passed = 0;

  // Reference model: architectural view of the fetch stage.
  int          m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_npc;
  logic        m_valid;
  bit          m_booting;
  bit          m_stalled;

  always #5 clk = ~clk;

  ins_fetch dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Addr    (addr),
    .Ins     (ins),
    .Stall   (stall),
    .Redirect(redirect),
    .Target  (target),
    .IR      (ir),
    .NPC     (npc),
    .Valid   (valid),
    .Fetching(fetching)
  );

  // IMEM model, combinational read.
  always_comb ins = (addr < 16'(DEPTH)) ? rom[addr[4:0]] : 16'h0000;

  function automatic int in_range(input int v);
    return (v >= DEPTH || v < 0) ? 0 : v;
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the expected post-edge state.
  task automatic step(input bit rst, input bit st, input bit rd, input logic [15:0] tgt);
    logic [15:0] fetched;
    int          off;
    @(negedge clk);
    rst_n    = rst;
    stall    = st;
    redirect = rd;
    target   = tgt;
    fetched  = rom[m_pc];
    if (!rst) begin
      m_pc = 0; m_ir = 16'h0000; m_npc = 16'h0000; m_valid = 1'b0;
      m_booting = 1'b1; m_stalled = 1'b0;
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (rd) begin
      m_pc = in_range(int'(tgt)); m_ir = 16'h0000; m_npc = 16'h0000; m_valid = 1'b0;
      m_stalled = 1'b0;
    end else if (st) begin
      m_stalled = 1'b1;
    end else begin
      m_ir = fetched; m_npc = 16'(m_pc + 1); m_valid = 1'b1; m_stalled = 1'b0;
`ifdef IF_JMP_PREDICT_EN
      if (fetched[15:11] == 5'b00110) begin
        off  = int'($signed(fetched[7:0]));
        m_pc = in_range(m_pc + off);
      end else begin
        m_pc = (m_pc + 1) % DEPTH;
      end
`else
      off  = 0;
      m_pc = (m_pc + 1 + off) % DEPTH;
`endif
    end
    exp_q.push_back('{addr: 16'(m_pc), ir: m_ir, npc: m_npc, valid: m_valid,
                      fetching: !m_booting && !m_stalled});
  endtask

  task automatic run_to(input int pc);
    int guard = 0;
    while (m_pc != pc && guard < 100) begin
      step(1'b1, 1'b0, 1'b0, 16'h0);
      guard++;
    end
    if (m_pc != pc) begin
      checks++;
      $display("FAIL run_to: model pc %0d, required %0d", m_pc, pc);
    end
  endtask

  // Monitor: pop one expectation per edge and compare the observed outputs.
  always @(posedge clk) begin
    obs_t e;
    obs_t a;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = '{addr: addr, ir: ir, npc: npc, valid: valid, fetching: fetching};
      checks++;
      if (a === e) passed++;
      else $display("FAIL if_id @%0t: got addr=%0d ir=%h npc=%0d valid=%b fetching=%b, required addr=%0d ir=%h npc=%0d valid=%b fetching=%b",
                    $time, a.addr, a.ir, a.npc, a.valid, a.fetching,
                    e.addr, e.ir, e.npc, e.valid, e.fetching);
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      rom[i] = 16'($urandom);
      if (rom[i][15:11] == 5'b00110) rom[i][15:11] = 5'b00001;
    end
    rom[0]  = 16'h180A;
    rom[22] = 16'h0C40;
    rom[28] = 16'h37F9;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; target = 16'h0;
    m_pc = 0; m_ir = 16'h0; m_npc = 16'h0; m_valid = 1'b0; m_booting = 1'b1; m_stalled = 1'b0;

    // Reset, boot bubble and first fetches.
    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b1, 16'h7);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 16'h0);
    // Three-cycle stall at PC=5, then release.
    run_to(5);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    // Redirect to 22 from PC=24.
    run_to(24);
    step(1'b1, 1'b0, 1'b1, 16'd22);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    // Redirect and Stall together, from RUN and from HOLD.
    step(1'b1, 1'b1, 1'b1, 16'd3);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 16'd9);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    // Wrap at the last word and out-of-range target.
    step(1'b1, 1'b0, 1'b1, 16'd29);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b1, 16'd40);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    // JMP word at PC=28.
    step(1'b1, 1'b0, 1'b1, 16'd28);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    // Reset while stalled.
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b1, 16'd12);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    // Random traffic, occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), 16'($urandom_range(0, 45)));
    end
    step(1'b1, 1'b0, 1'b0, 16'h0);
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
